// File: rtl/proc_boot_ctrl_pkg.sv
// proc_boot_ctrl_pkg: shared constants and state type for the boot controller
package proc_boot_ctrl_pkg;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  localparam logic [31:0] EBREAK_INSN = 32'h00100073;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {LOAD, FILL, HOLD, RUN, DONE, TMO} boot_state_t;
endpackage

// File: rtl/proc_boot_ctrl_if.sv
// proc_boot_ctrl_if: program-load stream, imem write port and core retire port
interface proc_boot_ctrl_if #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 6
);
  logic ld_valid;
  logic ld_ready;
  logic [XLEN-1:0] ld_data;
  logic ld_last;
  logic imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic retire_valid;
  logic [XLEN-1:0] retire_insn;
  modport slave (
    input ld_valid, ld_data, ld_last, retire_valid, retire_insn,
    output ld_ready, imem_we, imem_waddr, imem_wdata
  );
  modport master (
    output ld_valid, ld_data, ld_last, retire_valid, retire_insn,
    input ld_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/proc_boot_ctrl_sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input logic clk,
  input logic clr,
  input logic inc,
  output logic [W-1:0] q
);
  // count up while enabled, never wrapping past the maximum
  always_ff @(posedge clk)
    q <= clr ? '0 : q + W'(inc && !(&q));
endmodule

// File: rtl/proc_boot_ctrl.sv
// proc_boot_ctrl: program loader, core reset sequencer and run watchdog; NOP tail padding under PROC_BOOT_NOP_FILL_EN
module proc_boot_ctrl
  import proc_boot_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W = $clog2(IMEM_DEPTH),
  parameter int RESET_HOLD = 2,
  parameter int TIMEOUT = 1024,
  parameter logic [XLEN-1:0] HALT_INSN = XLEN'(EBREAK_INSN)
) (
  input logic clk,
  input logic reset,
  proc_boot_ctrl_if.slave bus,
  output logic core_resetn,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic done,
  output logic timeout,
  output logic overflow
);
  localparam int HW = RESET_HOLD > 1 ? $clog2(RESET_HOLD) : 1;
  boot_state_t state;
  logic [ADDR_W-1:0] wptr;
  logic [HW-1:0] hold_cnt;
  logic xfer, full, run;
  assign xfer = bus.ld_valid && bus.ld_ready;
  assign full = wptr == ADDR_W'(IMEM_DEPTH - 1);
  assign run = state == RUN;
  // boot sequencer: load image, optionally pad, hold core in reset, run until halt or watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      wptr <= '0;
      hold_cnt <= '0;
      bus.ld_ready <= 1'b0;
      bus.imem_we <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      core_resetn <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        LOAD: begin
          bus.ld_ready <= 1'b1;
          if (xfer) begin
            bus.imem_we <= 1'b1;
            bus.imem_waddr <= wptr;
            bus.imem_wdata <= bus.ld_data;
            wptr <= wptr + 1'b1;
            if (bus.ld_last || full) begin
              bus.ld_ready <= 1'b0;
              overflow <= full && !bus.ld_last;
`ifdef PROC_BOOT_NOP_FILL_EN
              state <= full ? HOLD : FILL;
`else
              state <= HOLD;
`endif
            end
          end
        end
`ifdef PROC_BOOT_NOP_FILL_EN
        FILL: begin
          bus.imem_we <= 1'b1;
          bus.imem_waddr <= wptr;
          bus.imem_wdata <= XLEN'(NOP_INSN);
          wptr <= wptr + 1'b1;
          if (full) state <= HOLD;
        end
`endif
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(RESET_HOLD - 1)) begin
            state <= RUN;
            core_resetn <= 1'b1;
          end
        end
        RUN: begin
          if (bus.retire_valid && bus.retire_insn == HALT_INSN) begin
            state <= DONE;
            done <= 1'b1;
            core_resetn <= 1'b0;
          end else if (cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= TMO;
            timeout <= 1'b1;
            core_resetn <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk),
    .clr(reset),
    .inc(run),
    .q(cycle_cnt)
  );
  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk),
    .clr(reset),
    .inc(run && bus.retire_valid),
    .q(retire_cnt)
  );
endmodule
